// File: rtl/apb_pkg.sv
// Shared types, widths and the address-region decode for the APB requester stage.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  localparam logic [1:0] REGION_SLV1 = 2'b00;
  localparam logic [1:0] REGION_SLV2 = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Returns one-hot {PSEL2, PSEL1}; all-zero means the address hits no slave.
  function automatic logic [1:0] apb_decode(input logic [1:0] region);
    logic [1:0] sel;
    case (region)
      REGION_SLV1: sel = 2'b01;
      REGION_SLV2: sel = 2'b10;
      default:     sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus between the requester stage and the two slaves.
interface apb_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating count of ACCESS cycles spent with PREADY low; flags the last allowed cycle.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q < CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the cycle whose low PREADY would complete TIMEOUT_CYCLES waits.
  assign expired = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts local requests, decodes two slave regions, runs SETUP/ACCESS
// with a bounded wait, and returns a one-cycle completion with data or error.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  apb_master_if.master      bus
);

  apb_state_e        state_q, state_d;
  logic              psel1_q, psel1_d;
  logic              psel2_q, psel2_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic [1:0] sel_dec;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_expired;

  assign sel_dec = apb_decode(req_addr[ADDR_W-1 -: 2]);

  always_comb begin
    state_d      = state_q;
    psel1_d      = 1'b0;
    psel2_d      = 1'b0;
    penable_d    = 1'b0;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (sel_dec != 2'b00) begin
            state_d  = ST_SETUP;
            psel1_d  = sel_dec[0];
            psel2_d  = sel_dec[1];
            pwrite_d = req_write;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
        end else if (timer_expired) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          psel1_d   = psel1_q;
          psel2_d   = psel2_q;
          penable_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      psel1_q      <= 1'b0;
      psel2_q      <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      psel1_q      <= psel1_d;
      psel2_q      <= psel2_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Wait budget restarts with every new transfer entering SETUP.
  assign timer_clear = (state_d == ST_SETUP);
  assign timer_en    = (state_q == ST_ACCESS) && !bus.PREADY;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (timer_clear),
    .count_en(timer_en),
    .expired (timer_expired)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign bus.PSEL1   = psel1_q;
  assign bus.PSEL2   = psel2_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;

endmodule

// File: doc/apb_master.md
# apb_master

Single-clock APB requester stage sitting directly upstream of the APB slaves. It accepts simple read/write requests from a local requester and decodes the address to one of two slave selects. It drives the two-phase APB SETUP/ACCESS protocol and returns read data plus a completion/error status. It also bounds slave wait states with a timeout, so a hung slave cannot stall the bus.

## Interface
Parameters:
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 8: APB data width.
- `TIMEOUT_CYCLES`, 15: maximum ACCESS cycles with PREADY low before abort (range 1–255).

Ports:
- `PCLK`  in  1  sole clock; all state updates on rising edge.
- `PRESET`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  requester has a transfer pending.
- `req_ready`  out  1  master can accept a request; high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with resp_valid: decode error or timeout.
- `resp_rdata`  out  DATA_W  read data, valid with resp_valid; 0 on write or error.
- `PSEL1`  out  1  select for slave region 0 (addr[7:6]=00).
- `PSEL2`  out  1  select for slave region 1 (addr[7:6]=01).
- `PENABLE`  out  1  ACCESS phase indicator.
- `PWRITE`  out  1  transfer direction.
- `PADDR`  out  ADDR_W  bus address.
- `PWDATA`  out  DATA_W  bus write data.
- `PRDATA`  in  DATA_W  read data from the selected slave.
- `PREADY`  in  1  slave completion, sampled only in ACCESS.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: `req_ready`=1. On `req_valid`, capture write/addr/wdata into registers.
  - If `addr[7:6]` is 00 or 01 → SETUP.
  - Otherwise (decode error) → stay IDLE. Next cycle: `resp_valid`=1, `resp_err`=1, `resp_rdata`=0. No PSEL is asserted.
- SETUP: exactly one cycle. Selected PSELx=1, PENABLE=0, and PADDR/PWRITE/PWDATA driven from the captured registers → ACCESS.
- ACCESS: PSELx=1, PENABLE=1; address, control and data held stable.
  - PREADY=1 → IDLE. On a read, capture PRDATA into `resp_rdata`. Next cycle: `resp_valid`=1, `resp_err`=0.
  - PREADY=0 → increment the wait counter.
  - Counter reaches TIMEOUT_CYCLES with PREADY still 0 → abort to IDLE. Next cycle: `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
- The wait counter clears on every entry to SETUP. It is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates; it never wraps.
- Outside SETUP/ACCESS: PSEL1, PSEL2 and PENABLE are 0. PADDR, PWDATA and PWRITE hold their last values.
- A request presented while not in IDLE is not accepted; the requester holds it until `req_ready`.
- PSEL1 and PSEL2 are never high together.

## Timing
- All outputs registered, except `req_ready`, which is decoded from the state register.
- Reset values: state=IDLE, all P* outputs 0, `resp_valid`/`resp_err`/`resp_rdata`=0, wait counter 0.
- Reset in any state forces these values at the next edge and abandons any in-flight transfer. No response is generated for the abandoned transfer.
- Zero-wait transfer, request accepted at edge of cycle N:
  - SETUP in N+1.
  - ACCESS in N+2.
  - `resp_valid` in N+3.
  - `req_ready` high again in N+3, so the next SETUP is no earlier than N+4.
- k wait states: `resp_valid` at N+3+k.
- Timeout: ACCESS lasts TIMEOUT_CYCLES cycles, then the error response follows in the next cycle.
- Decode error: `resp_valid` in N+1.
- `resp_valid` is always a single-cycle pulse and never coincides with PSELx=1.

## Structure
- Package `apb_pkg`:
  - state enum (IDLE/SETUP/ACCESS);
  - APB_ADDR_W/APB_DATA_W defaults;
  - region constants REGION_SLV1=2'b00, REGION_SLV2=2'b01;
  - the decode function mapping `addr[7:6]` → one-hot select / error.
- One sub-module, `apb_wait_timer`:
  - holds the saturating wait counter;
  - inputs clear, count-enable;
  - output `expired`.
- FSM, request capture and response registers stay in `apb_master`.

## Test plan
- Reset: assert PRESET 2 cycles mid-ACCESS → next edge all P* outputs 0, state IDLE, `req_ready`=1, no `resp_valid`.
- Write 0xA5 to 0x05, PREADY tied 1 → N+1: PSEL1=1, PENABLE=0, PADDR=0x05, PWDATA=0xA5, PWRITE=1; N+2: PENABLE=1; N+3: `resp_valid`=1, `resp_err`=0.
- Read 0x45, slave returns PRDATA=0x3C with PREADY=1 → PSEL2 asserted (PSEL1=0); `resp_rdata`=0x3C at N+3.
- Read 0x10, PREADY low 3 ACCESS cycles then high → PADDR stable throughout; `resp_valid` at N+6, `resp_err`=0.
- Write 0x20, PREADY never high, TIMEOUT_CYCLES=15 → PENABLE high exactly 15 cycles; then `resp_valid`=1, `resp_err`=1, `resp_rdata`=0x00, bus idle.
- Request to 0x80 → no PSEL asserted; `resp_valid`=1, `resp_err`=1 at N+1; an immediate follow-up request to 0x01 proceeds normally.
